hazard_stall_unit: RTL and testbench



---
 rtl/hazard_pkg.sv | 30 +++
 rtl/raw_detect.sv | 18 +
 rtl/hazard_stall_unit.sv | 123 ++++++++++++
 tb/tb_hazard_stall_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/stall unit: FSM encoding and
// the bundle of pipeline control enables it drives.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    RAW_STALL = 2'd1,
    MEM_WAIT  = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_ZERO        = 5'd0;
  localparam int         DEFAULT_BUBBLES = 1;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_bubble;
    logic pipe_freeze;
    logic if_id_flush;
    logic id_ex_flush;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RUN    = '{pc_write: 1'b1, if_id_write: 1'b1, default: 1'b0};
  localparam hz_ctrl_t CTRL_BUBBLE = '{id_ex_bubble: 1'b1, default: 1'b0};
  localparam hz_ctrl_t CTRL_FREEZE = '{pipe_freeze: 1'b1, default: 1'b0};
  localparam hz_ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, if_id_write: 1'b1,
                                       if_id_flush: 1'b1, id_ex_flush: 1'b1,
                                       default: 1'b0};

endpackage

// File: rtl/raw_detect.sv
// Combinational RAW comparator: producer in EX vs. source registers in ID.
// Kept separate so an EX/MEM forwarding path can reuse it.
module raw_detect
  import hazard_pkg::*;
(
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       use_rs2_i,
  input  logic [4:0] rd_i,
  input  logic       reg_write_i,
  output logic       raw_hit_o
);

  // A single OR keeps rd==rs1==rs2 to one hit.
  assign raw_hit_o = reg_write_i && (rd_i != REG_ZERO) &&
                     ((rd_i == rs1_i) || (use_rs2_i && (rd_i == rs2_i)));

endmodule

// File: rtl/hazard_stall_unit.sv
// RAW stall / memory freeze / branch flush control beside the ID stage.
// Optional perf counters: define HAZARD_PERF_CNT_EN.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int BUBBLES = DEFAULT_BUBBLES,
  parameter int CNT_W   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] IF_ID_Rs1,
  input  logic [4:0] IF_ID_Rs2,
  input  logic       IF_ID_useRs2,
  input  logic [4:0] ID_EX_Rd,
  input  logic       ID_EX_regWrite,
  input  logic       EX_branchTaken,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       pc_write,
  output logic       IF_ID_write,
  output logic       ID_EX_bubble,
  output logic       pipe_freeze,
  output logic       IF_ID_flush,
  output logic       ID_EX_flush,
  output logic       stall_active
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_stalls,
  output logic [31:0] perf_flushes
`endif
);

  hz_state_e        state_q, state_d, eff_state;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             raw_hit, mem_wait;
  hz_ctrl_t         ctrl;

  raw_detect u_raw_detect (
    .rs1_i       (IF_ID_Rs1),
    .rs2_i       (IF_ID_Rs2),
    .use_rs2_i   (IF_ID_useRs2),
    .rd_i        (ID_EX_Rd),
    .reg_write_i (ID_EX_regWrite),
    .raw_hit_o   (raw_hit)
  );

  assign mem_wait = dmem_req && !dmem_ready;

  // The cycle the memory releases behaves as the state that was interrupted,
  // so a suspended RAW stall resumes with no idle slot in between.
  assign eff_state = (state_q == MEM_WAIT) ? ((cnt_q != '0) ? RAW_STALL : RUN)
                                           : state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (mem_wait) begin
      state_d = MEM_WAIT;
    end else if (EX_branchTaken) begin
      state_d = RUN;
      cnt_d   = '0;
    end else begin
      case (eff_state)
        RAW_STALL: begin
          cnt_d   = cnt_q - CNT_W'(1);
          state_d = (cnt_q == CNT_W'(1)) ? RUN : RAW_STALL;
        end
        default: begin
          state_d = RUN;
          if (raw_hit && (BUBBLES > 1)) begin
            state_d = RAW_STALL;
            cnt_d   = CNT_W'(BUBBLES - 1);
          end
        end
      endcase
    end
  end

  // Reset forces the enables directly so they do not follow live hazard inputs.
  always_comb begin
    ctrl = CTRL_RUN;
    if (!rst_n)                                    ctrl = CTRL_RUN;
    else if (mem_wait)                             ctrl = CTRL_FREEZE;
    else if (EX_branchTaken)                       ctrl = CTRL_FLUSH;
    else if (eff_state == RAW_STALL || raw_hit)    ctrl = CTRL_BUBBLE;
  end

  assign pc_write     = ctrl.pc_write;
  assign IF_ID_write  = ctrl.if_id_write;
  assign ID_EX_bubble = ctrl.id_ex_bubble;
  assign pipe_freeze  = ctrl.pipe_freeze;
  assign IF_ID_flush  = ctrl.if_id_flush;
  assign ID_EX_flush  = ctrl.id_ex_flush;
  assign stall_active = rst_n && ((state_q != RUN) || !ctrl.pc_write);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stalls_q, perf_flushes_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stalls_q  <= '0;
      perf_flushes_q <= '0;
    end else begin
      if (ctrl.id_ex_bubble) perf_stalls_q  <= perf_stalls_q + 32'd1;
      if (ctrl.if_id_flush)  perf_flushes_q <= perf_flushes_q + 32'd1;
    end
  end

  assign perf_stalls  = perf_stalls_q;
  assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: one instance with BUBBLES=1, one with
// BUBBLES=3, sharing inputs. Outputs are sampled mid-cycle.
module tb_hazard_stall_unit;
  import hazard_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] IF_ID_Rs1, IF_ID_Rs2, ID_EX_Rd;
  logic       IF_ID_useRs2, ID_EX_regWrite, EX_branchTaken, dmem_req, dmem_ready;

  logic pcw_a, ifw_a, bub_a, frz_a, iff_a, exf_a, stl_a;
  logic pcw_b, ifw_b, bub_b, frz_b, iff_b, exf_b, stl_b;
  logic [6:0] outs_a, outs_b;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] ps_a, pf_a, ps_b, pf_b;
`endif

  // {pc_write, IF_ID_write, bubble, freeze, IF_ID_flush, ID_EX_flush, stall_active}
  localparam logic [6:0] NORM  = 7'b1100000;
  localparam logic [6:0] BUB   = 7'b0010001;
  localparam logic [6:0] FRZ   = 7'b0001001;
  localparam logic [6:0] FLS   = 7'b1100110;
  localparam logic [6:0] FLS_S = 7'b1100111;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  always #5 clk = ~clk;

  assign outs_a = {pcw_a, ifw_a, bub_a, frz_a, iff_a, exf_a, stl_a};
  assign outs_b = {pcw_b, ifw_b, bub_b, frz_b, iff_b, exf_b, stl_b};

  hazard_stall_unit #(.BUBBLES(1), .CNT_W(3)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_Rs1(IF_ID_Rs1), .IF_ID_Rs2(IF_ID_Rs2), .IF_ID_useRs2(IF_ID_useRs2),
    .ID_EX_Rd(ID_EX_Rd), .ID_EX_regWrite(ID_EX_regWrite),
    .EX_branchTaken(EX_branchTaken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pcw_a), .IF_ID_write(ifw_a), .ID_EX_bubble(bub_a),
    .pipe_freeze(frz_a), .IF_ID_flush(iff_a), .ID_EX_flush(exf_a),
    .stall_active(stl_a)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stalls(ps_a), .perf_flushes(pf_a)
`endif
  );

  hazard_stall_unit #(.BUBBLES(3), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_Rs1(IF_ID_Rs1), .IF_ID_Rs2(IF_ID_Rs2), .IF_ID_useRs2(IF_ID_useRs2),
    .ID_EX_Rd(ID_EX_Rd), .ID_EX_regWrite(ID_EX_regWrite),
    .EX_branchTaken(EX_branchTaken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pcw_b), .IF_ID_write(ifw_b), .ID_EX_bubble(bub_b),
    .pipe_freeze(frz_b), .IF_ID_flush(iff_b), .ID_EX_flush(exf_b),
    .stall_active(stl_b)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stalls(ps_b), .perf_flushes(pf_b)
`endif
  );

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic use2,
                        input logic [4:0] rd, input logic rw, input logic br,
                        input logic req, input logic rdy);
    IF_ID_Rs1 = rs1; IF_ID_Rs2 = rs2; IF_ID_useRs2 = use2;
    ID_EX_Rd = rd; ID_EX_regWrite = rw; EX_branchTaken = br;
    dmem_req = req; dmem_ready = rdy;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    tot_cnt++; if (outs_a !== NORM) $display("FAIL reset_a got %b exp %b", outs_a, NORM); else pass_cnt++;
    tot_cnt++; if (outs_b !== NORM) $display("FAIL reset_b got %b exp %b", outs_b, NORM); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_raw_b1();
    do_reset(); cyc();
    set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); #2;
    tot_cnt++; if (outs_a !== BUB) $display("FAIL raw_b1_hit got %b exp %b", outs_a, BUB); else pass_cnt++;
    cyc();
    set_in(5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #2;
    tot_cnt++; if (outs_a !== NORM) $display("FAIL raw_b1_after got %b exp %b", outs_a, NORM); else pass_cnt++;
  endtask

  task automatic test_raw_b3();
    do_reset(); cyc();
    set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); #2;
    tot_cnt++; if (outs_b !== BUB) $display("FAIL raw_b3_c1 got %b exp %b", outs_b, BUB); else pass_cnt++;
    for (int i = 2; i <= 3; i++) begin
      cyc();
      set_in(5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #2;
      tot_cnt++; if (outs_b !== BUB) $display("FAIL raw_b3_c%0d got %b exp %b", i, outs_b, BUB); else pass_cnt++;
    end
    cyc(); #1;
    tot_cnt++; if (outs_b !== NORM) $display("FAIL raw_b3_done got %b exp %b", outs_b, NORM); else pass_cnt++;
`ifdef HAZARD_PERF_CNT_EN
    tot_cnt++; if (ps_b !== 32'd3) $display("FAIL perf_stalls_b got %0d exp 3", ps_b); else pass_cnt++;
`endif
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    tot_cnt++; if (outs_b !== NORM) $display("FAIL x0_b got %b exp %b", outs_b, NORM); else pass_cnt++;
    tot_cnt++; if (outs_a !== NORM) $display("FAIL x0_a got %b exp %b", outs_a, NORM); else pass_cnt++;
  endtask

  task automatic test_rs2();
    do_reset(); cyc();
    set_in(5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0); #2;
    tot_cnt++; if (outs_a !== NORM) $display("FAIL rs2_unused got %b exp %b", outs_a, NORM); else pass_cnt++;
    IF_ID_useRs2 = 1'b1; #1;
    tot_cnt++; if (outs_a !== BUB) $display("FAIL rs2_used got %b exp %b", outs_a, BUB); else pass_cnt++;
    cyc();
    set_in(5'd9, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0); #2;
    tot_cnt++; if (outs_a !== BUB) $display("FAIL rd_eq_both got %b exp %b", outs_a, BUB); else pass_cnt++;
    cyc();
    set_in(5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #2;
    tot_cnt++; if (outs_a !== NORM) $display("FAIL rd_eq_both_once got %b exp %b", outs_a, NORM); else pass_cnt++;
  endtask

  task automatic test_mem_wait();
    do_reset(); cyc();
    set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); #2;
    tot_cnt++; if (outs_b !== BUB) $display("FAIL mw_hit got %b exp %b", outs_b, BUB); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      cyc();
      set_in(5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); #2;
      tot_cnt++; if (outs_b !== FRZ) $display("FAIL mw_freeze%0d got %b exp %b", i, outs_b, FRZ); else pass_cnt++;
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      set_in(5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); #2;
      tot_cnt++; if (outs_b !== BUB) $display("FAIL mw_resume%0d got %b exp %b", i, outs_b, BUB); else pass_cnt++;
    end
    cyc();
    set_in(5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #2;
    tot_cnt++; if (outs_b !== NORM) $display("FAIL mw_done got %b exp %b", outs_b, NORM); else pass_cnt++;
    set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0); #1;
    tot_cnt++; if (outs_a !== FRZ) $display("FAIL mw_over_branch got %b exp %b", outs_a, FRZ); else pass_cnt++;
  endtask

  task automatic test_branch();
    do_reset(); cyc();
    set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0); #2;
    tot_cnt++; if (outs_a !== FLS) $display("FAIL br_raw_a got %b exp %b", outs_a, FLS); else pass_cnt++;
    tot_cnt++; if (outs_b !== FLS) $display("FAIL br_raw_b got %b exp %b", outs_b, FLS); else pass_cnt++;
    cyc();
    set_in(5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #2;
    tot_cnt++; if (outs_b !== NORM) $display("FAIL br_next_b got %b exp %b", outs_b, NORM); else pass_cnt++;
`ifdef HAZARD_PERF_CNT_EN
    tot_cnt++; if (pf_a !== 32'd1) $display("FAIL perf_flushes_a got %0d exp 1", pf_a); else pass_cnt++;
`endif
    set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    tot_cnt++; if (outs_b !== BUB) $display("FAIL br_stall_start got %b exp %b", outs_b, BUB); else pass_cnt++;
    cyc();
    set_in(5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); #2;
    tot_cnt++; if (outs_b !== FLS_S) $display("FAIL br_in_stall got %b exp %b", outs_b, FLS_S); else pass_cnt++;
    cyc();
    set_in(5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #2;
    tot_cnt++; if (outs_b !== NORM) $display("FAIL br_discard got %b exp %b", outs_b, NORM); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    do_reset(); cyc();
    set_in(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    #1 rst_n = 1'b0;
    #1;
    tot_cnt++; if (outs_b !== NORM) $display("FAIL arst_b got %b exp %b", outs_b, NORM); else pass_cnt++;
    tot_cnt++; if (outs_a !== NORM) $display("FAIL arst_a got %b exp %b", outs_a, NORM); else pass_cnt++;
`ifdef HAZARD_PERF_CNT_EN
    tot_cnt++; if (ps_b !== 32'd0) $display("FAIL arst_perf got %0d exp 0", ps_b); else pass_cnt++;
`endif
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    #1;
    tot_cnt++; if (outs_b !== NORM) $display("FAIL arst_release got %b exp %b", outs_b, NORM); else pass_cnt++;
    cyc();
    set_in(5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0); #2;
    tot_cnt++; if (outs_b !== BUB) $display("FAIL arst_new1 got %b exp %b", outs_b, BUB); else pass_cnt++;
    for (int i = 2; i <= 3; i++) begin
      cyc();
      set_in(5'd6, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); #2;
      tot_cnt++; if (outs_b !== BUB) $display("FAIL arst_new%0d got %b exp %b", i, outs_b, BUB); else pass_cnt++;
    end
    cyc(); #1;
    tot_cnt++; if (outs_b !== NORM) $display("FAIL arst_new_done got %b exp %b", outs_b, NORM); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_raw_b1();
    test_raw_b3();
    test_rs2();
    test_mem_wait();
    test_branch();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
